// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the memory controller and its BIST request master.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT, DONE} state_t;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // Word-address width for an R x C array; never narrower than one bit.
  function automatic int aw_calc(input int r, input int c);
    return (r * c > 1) ? $clog2(r * c) : 1;
  endfunction

endpackage

// File: rtl/mem_bist_err_log.sv
// Mismatch logger: saturating error count and first failing address.
module mem_bist_err_log #(
  parameter int AW = 4,
  parameter int N  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          cmp_en,
  input  logic [N-1:0]  exp,
  input  logic [N-1:0]  act,
  input  logic [AW-1:0] addr,
  output logic [AW:0]   err_cnt,
  output logic [AW-1:0] first_err_addr
);

  logic miss;
  assign miss = cmp_en && (exp != act);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else if (clr) begin
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else if (miss) begin
      // A saturated count never returns to zero, so capture happens only once.
      if (err_cnt == '0) first_err_addr <= addr;
      if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_bist_master.sv
// BIST request master: write pat(a) everywhere, read back and compare.
// Define MEM_BIST_INV_PASS_EN to add a second write/read pass with inverted pattern.
module mem_bist_master
  import mem_ctrl_pkg::*;
#(
  parameter int          R       = 4,
  parameter int          C       = 4,
  parameter int          N       = 4,
  parameter logic [N-1:0] SEED   = 'hA,
  parameter int          TIMEOUT = 15,
  localparam int         AW      = aw_calc(R, C)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          timeout,
  output logic [AW:0]   err_cnt,
  output logic [AW-1:0] first_err_addr,
  output logic          cs,
  output logic          req,
  output logic          rw,
  output logic [AW-1:0] addr,
  output logic [N-1:0]  Qi,
  input  logic [N-1:0]  Qa,
  input  logic          valid,
  input  logic          ready
);

  localparam int            CW   = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] LAST = AW'(R * C - 1);

  state_t        state, state_n;
  logic [AW-1:0] addr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [N-1:0]  exp_q, exp_n, pat_cur;
  logic          to_n, clr, progress, active;
`ifdef MEM_BIST_INV_PASS_EN
  logic          inv, inv_n;
  assign pat_cur = N'(addr) ^ SEED ^ {N{inv}};
`else
  assign pat_cur = N'(addr) ^ SEED;
`endif

  assign active   = (state == WR_REQ) || (state == RD_REQ) || (state == RD_WAIT);
  assign progress = (state == RD_WAIT) ? valid : ready;

  always_comb begin
    state_n = state;
    addr_n  = addr;
    cnt_n   = cnt;
    exp_n   = exp_q;
    to_n    = timeout;
    clr     = 1'b0;
`ifdef MEM_BIST_INV_PASS_EN
    inv_n   = inv;
`endif
    case (state)
      IDLE, DONE: if (start) begin
        clr     = 1'b1;
        to_n    = 1'b0;
        addr_n  = '0;
        cnt_n   = '0;
        state_n = WR_REQ;
`ifdef MEM_BIST_INV_PASS_EN
        inv_n   = 1'b0;
`endif
      end
      WR_REQ: if (ready) begin
        if (addr == LAST) begin
          addr_n  = '0;
          state_n = RD_REQ;
        end else addr_n = addr + 1'b1;
      end
      RD_REQ: if (ready) begin
        exp_n   = pat_cur;
        state_n = RD_WAIT;
      end
      RD_WAIT: if (valid) begin
        if (addr == LAST) begin
`ifdef MEM_BIST_INV_PASS_EN
          if (!inv) begin
            inv_n   = 1'b1;
            addr_n  = '0;
            state_n = WR_REQ;
          end else state_n = DONE;
`else
          state_n = DONE;
`endif
        end else begin
          addr_n  = addr + 1'b1;
          state_n = RD_REQ;
        end
      end
      default: state_n = IDLE;
    endcase
    // A transfer in the expiry cycle wins; only a stalled cycle can abort.
    if (active) begin
      if (progress) cnt_n = '0;
      else if (cnt == CW'(TIMEOUT - 1)) begin
        to_n    = 1'b1;
        cnt_n   = '0;
        state_n = DONE;
      end else cnt_n = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr    <= '0;
      cnt     <= '0;
      exp_q   <= '0;
      timeout <= 1'b0;
`ifdef MEM_BIST_INV_PASS_EN
      inv     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      addr    <= addr_n;
      cnt     <= cnt_n;
      exp_q   <= exp_n;
      timeout <= to_n;
`ifdef MEM_BIST_INV_PASS_EN
      inv     <= inv_n;
`endif
    end
  end

  assign busy = active;
  assign done = (state == DONE);
  assign pass = done && (err_cnt == '0) && !timeout;
  assign cs   = (state == WR_REQ) || (state == RD_REQ);
  assign req  = cs;
  assign rw   = (state == RD_REQ) ? RW_READ : RW_WRITE;
  assign Qi   = (state == WR_REQ) ? pat_cur : '0;

  mem_bist_err_log #(.AW(AW), .N(N)) u_err_log (
    .clk            (clk),
    .rst            (rst),
    .clr            (clr),
    .cmp_en         ((state == RD_WAIT) && valid),
    .exp            (exp_q),
    .act            (Qa),
    .addr           (addr),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr)
  );

endmodule
